// File: rtl/wb_pkg.sv
// Shared Wishbone burst types plus the address-offset and burst
// next-address helpers used by the BRAM slave.
package wb_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_BURST
    } rd_state_t;

    // Byte-offset bits below the word index.
    function automatic int calc_ofs(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Wrapping bursts only advance the low index bits; linear wraps at the memory depth.
    function automatic logic [31:0] next_word_idx(input logic [31:0] idx,
                                                  input bte_t        bte,
                                                  input int          mem_adr_w);
        logic [31:0] depth_mask;
        logic [31:0] wrap_mask;
        logic [31:0] inc;
        depth_mask = (32'd1 << mem_adr_w) - 32'd1;
        inc        = idx + 32'd1;
        case (bte)
            BTE_WRAP4:  wrap_mask = 32'h0000_0003;
            BTE_WRAP8:  wrap_mask = 32'h0000_0007;
            BTE_WRAP16: wrap_mask = 32'h0000_000F;
            default:    wrap_mask = depth_mask;
        endcase
        return ((idx & ~wrap_mask) | (inc & wrap_mask)) & depth_mask;
    endfunction

endpackage

// File: rtl/bram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The output register only updates on a read, so it holds the last read word.
module bram_sp_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] dout_lane_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (be[gi]) begin
                            mem[addr] <= din[gi*8 +: 8];
                        end
                    end else begin
                        dout_lane_q <= mem[addr];
                    end
                end
            end

            assign dout[gi*8 +: 8] = dout_lane_q;
        end
    endgenerate

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 registered-feedback BRAM slave: zero-wait writes, reads with one
// wait state, then one beat per cycle for linear and wrapping bursts.
module wb_bram_burst
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_ADR_W = 11,
    parameter int ADR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADR_W-1:0]      adr,
    input  logic [DATA_W-1:0]     dat_ms,
    output logic [DATA_W-1:0]     dat_sm,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic                  we,
    input  logic                  stb,
    input  logic                  cyc,
    input  logic [2:0]            cti,
    input  logic [1:0]            bte,
    output logic                  ack,
    output logic                  err,
    output logic                  rty
);

    localparam int OFS = calc_ofs(DATA_W);

    rd_state_t              state_q, state_d;
    logic                   rd_ack_q, rd_ack_d;
    logic [MEM_ADR_W-1:0]   pred_q, pred_d;

    logic [MEM_ADR_W-1:0]   word_idx;
    logic                   in_range;
    logic                   req;
    logic                   rd_req;
    logic                   wr_ack;
    logic                   beat_hit;
    logic [31:0]            nxt_full;
    logic [MEM_ADR_W-1:0]   nxt_idx;
    logic                   ram_rd;
    logic                   ram_en;
    logic [MEM_ADR_W-1:0]   ram_addr;
    logic [MEM_ADR_W-1:0]   rd_addr;
    logic                   unused_bits;

    assign word_idx = adr[MEM_ADR_W+OFS-1:OFS];
    assign in_range = (adr[ADR_W-1:MEM_ADR_W+OFS] == '0);

    // Gating with rst_n keeps ack/err low and the RAM idle while reset is held.
    assign req    = rst_n & cyc & stb;
    assign rd_req = req & ~we & in_range;
    assign wr_ack = req & we & in_range;
    assign err    = req & ~in_range;
    assign rty    = 1'b0;

    // A read beat is acked only when the registered data matches the word asked for.
    assign beat_hit = rd_ack_q & rd_req & (word_idx == pred_q);
    assign ack      = wr_ack | beat_hit;

    assign nxt_full    = next_word_idx({{(32-MEM_ADR_W){1'b0}}, pred_q}, bte_t'(bte), MEM_ADR_W);
    assign nxt_idx     = nxt_full[MEM_ADR_W-1:0];
    assign unused_bits = ^{nxt_full[31:MEM_ADR_W], adr[OFS-1:0]};

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        ram_rd  = 1'b0;
        rd_addr = word_idx;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    ram_rd  = 1'b1;
                    rd_addr = word_idx;
                    pred_d  = word_idx;
                    state_d = ST_RD;
                end
            end
            ST_RD, ST_BURST: begin
                if (beat_hit && (cti == CTI_INCR)) begin
                    ram_rd  = 1'b1;
                    rd_addr = nxt_idx;
                    pred_d  = nxt_idx;
                    state_d = ST_BURST;
                end else begin
                    // Burst end, or any broken beat: fall back and restart later.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rd_ack_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_ack_q <= 1'b0;
            pred_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ack_q <= rd_ack_d;
            pred_q   <= pred_d;
        end
    end

    // Reads and writes never coincide since a read request requires we = 0.
    assign ram_en   = wr_ack | ram_rd;
    assign ram_addr = wr_ack ? word_idx : rd_addr;

    bram_sp_be #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (wr_ack),
        .be   (sel),
        .addr (ram_addr),
        .din  (dat_ms),
        .dout (dat_sm)
    );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: writes, byte lanes, linear and wrap bursts,
// out-of-range errors and reset in the middle of a burst.
module tb_wb_bram_burst;

    localparam int DATA_W    = 32;
    localparam int MEM_ADR_W = 11;
    localparam int ADR_W     = 32;
    localparam logic [31:0] OOR_ADR = 32'h1 << (MEM_ADR_W + 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADR_W-1:0]  adr = '0;
    logic [DATA_W-1:0] dat_ms = '0;
    logic [DATA_W-1:0] dat_sm;
    logic [3:0]        sel = '0;
    logic              we = 1'b0;
    logic              stb = 1'b0;
    logic              cyc = 1'b0;
    logic [2:0]        cti = '0;
    logic [1:0]        bte = '0;
    logic              ack;
    logic              err;
    logic              rty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_bram_burst #(
        .DATA_W    (DATA_W),
        .MEM_ADR_W (MEM_ADR_W),
        .ADR_W     (ADR_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .adr    (adr),
        .dat_ms (dat_ms),
        .dat_sm (dat_sm),
        .sel    (sel),
        .we     (we),
        .stb    (stb),
        .cyc    (cyc),
        .cti    (cti),
        .bte    (bte),
        .ack    (ack),
        .err    (err),
        .rty    (rty)
    );

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic cycle(input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
        @(posedge clk);
        #1;
        cyc = c; stb = s; we = w; adr = a; dat_ms = d; sel = sl; cti = ct; bte = bt;
        @(negedge clk);
    endtask

    task automatic go_idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    task automatic test_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; sel = 4'hF; dat_ms = 32'h1;
        #3;
        if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++;
        if (rty !== 1'b0) begin bad++; $display("FAIL reset_rty: got %b want 0", rty); end
        total++;
        adr = OOR_ADR;
        #1;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err_oor: got %b want 0", err); end
        total++;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
        rst_n = 1'b1;
        @(negedge clk);
        if (ack !== 1'b0) begin bad++; $display("FAIL post_reset_ack: got %b want 0", ack); end
        total++;
        $display("test_reset done");
    endtask

    task automatic test_single_write_read();
        cycle(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1) begin bad++; $display("FAIL single_wr_ack: got %b want 1", ack); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL single_wr_err: got %b want 0", err); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0) begin bad++; $display("FAIL single_rd_wait: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1) begin bad++; $display("FAIL single_rd_ack: got %b want 1", ack); end
        total++;
        if (dat_sm !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_rd_data: got %h want deadbeef", dat_sm);
        end
        total++;
        go_idle();
        if (ack !== 1'b0) begin bad++; $display("FAIL single_idle_ack: got %b want 0", ack); end
        total++;
        $display("test_single_write_read done");
    endtask

    task automatic test_byte_write();
        cycle(1'b1, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1) begin bad++; $display("FAIL byte_full_wr_ack: got %b want 1", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010, 3'b000, 2'b00);
        if (ack !== 1'b1) begin bad++; $display("FAIL byte_lane_wr_ack: got %b want 1", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0) begin bad++; $display("FAIL byte_rd_wait: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1 || dat_sm !== 32'h1122_AB44) begin
            bad++; $display("FAIL byte_rd: got ack=%b data=%h want ack=1 data=1122ab44", ack, dat_sm);
        end
        total++;
        go_idle();
        $display("test_byte_write done");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'b000, 2'b00);
            if (ack !== 1'b1) begin bad++; $display("FAIL fill_ack[%0d]: got %b want 1", i, ack); end
            total++;
        end
        go_idle();
        $display("test_fill done");
    endtask

    task automatic test_linear_burst();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b00);
        if (ack !== 1'b0) begin bad++; $display("FAIL lin_wait: got %b want 0", ack); end
        total++;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'(k * 4), 32'h0, 4'hF, (k == 7) ? 3'b111 : 3'b010, 2'b00);
            if (ack !== 1'b1 || dat_sm !== 32'hA000_0000 + 32'(k)) begin
                bad++;
                $display("FAIL lin_beat[%0d]: got ack=%b data=%h want ack=1 data=%h",
                         k, ack, dat_sm, 32'hA000_0000 + 32'(k));
            end
            total++;
        end
        go_idle();
        if (ack !== 1'b0) begin bad++; $display("FAIL lin_end_ack: got %b want 0", ack); end
        total++;
        $display("test_linear_burst done");
    endtask

    task automatic test_wrap4();
        int ord [4] = '{6, 7, 4, 5};
        cycle(1'b1, 1'b1, 1'b0, 32'd24, 32'h0, 4'hF, 3'b010, 2'b01);
        if (ack !== 1'b0) begin bad++; $display("FAIL wrap_wait: got %b want 0", ack); end
        total++;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'(ord[k] * 4), 32'h0, 4'hF, (k == 3) ? 3'b111 : 3'b010, 2'b01);
            if (ack !== 1'b1 || dat_sm !== 32'hA000_0000 + 32'(ord[k])) begin
                bad++;
                $display("FAIL wrap_beat[%0d]: got ack=%b data=%h want ack=1 data=%h",
                         k, ack, dat_sm, 32'hA000_0000 + 32'(ord[k]));
            end
            total++;
        end
        go_idle();
        // Master wrongly steps to word 8 after word 7.
        cycle(1'b1, 1'b1, 1'b0, 32'd24, 32'h0, 4'hF, 3'b010, 2'b01);
        cycle(1'b1, 1'b1, 1'b0, 32'd24, 32'h0, 4'hF, 3'b010, 2'b01);
        if (ack !== 1'b1) begin bad++; $display("FAIL jump_beat6: got %b want 1", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd28, 32'h0, 4'hF, 3'b010, 2'b01);
        if (ack !== 1'b1) begin bad++; $display("FAIL jump_beat7: got %b want 1", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd32, 32'h0, 4'hF, 3'b010, 2'b01);
        if (ack !== 1'b0) begin bad++; $display("FAIL jump_mismatch: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd32, 32'h0, 4'hF, 3'b111, 2'b01);
        if (ack !== 1'b0) begin bad++; $display("FAIL jump_restart_wait: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd32, 32'h0, 4'hF, 3'b111, 2'b01);
        if (ack !== 1'b1 || dat_sm !== 32'hA000_0008) begin
            bad++; $display("FAIL jump_restart: got ack=%b data=%h want ack=1 data=a0000008", ack, dat_sm);
        end
        total++;
        go_idle();
        $display("test_wrap4 done");
    endtask

    task automatic test_out_of_range();
        cycle(1'b1, 1'b1, 1'b1, OOR_ADR, 32'h55AA_55AA, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0 || err !== 1'b1) begin
            bad++; $display("FAIL oor_wr: got ack=%b err=%b want ack=0 err=1", ack, err);
        end
        total++;
        cycle(1'b1, 1'b1, 1'b0, OOR_ADR, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0 || err !== 1'b1) begin
            bad++; $display("FAIL oor_rd: got ack=%b err=%b want ack=0 err=1", ack, err);
        end
        total++;
        cycle(1'b1, 1'b1, 1'b0, OOR_ADR, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0 || err !== 1'b1) begin
            bad++; $display("FAIL oor_rd_hold: got ack=%b err=%b want ack=0 err=1", ack, err);
        end
        total++;
        cycle(1'b0, 1'b1, 1'b0, OOR_ADR, 32'h0, 4'hF, 3'b000, 2'b00);
        if (err !== 1'b0) begin bad++; $display("FAIL oor_no_cyc: got %b want 0", err); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL oor_chk_wait: got ack=%b err=%b want ack=0 err=0", ack, err);
        end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1 || dat_sm !== 32'hA000_0000) begin
            bad++; $display("FAIL oor_mem_unchanged: got ack=%b data=%h want ack=1 data=a0000000", ack, dat_sm);
        end
        total++;
        go_idle();
        $display("test_out_of_range done");
    endtask

    task automatic test_reset_mid_burst();
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b00);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'(k * 4), 32'h0, 4'hF, 3'b010, 2'b00);
            if (ack !== 1'b1) begin bad++; $display("FAIL rstb_beat[%0d]: got %b want 1", k, ack); end
            total++;
        end
        @(posedge clk);
        #1;
        adr = 32'd12; cti = 3'b010;
        #1;
        if (ack !== 1'b1 || dat_sm !== 32'hA000_0003) begin
            bad++; $display("FAIL rstb_beat3: got ack=%b data=%h want ack=1 data=a0000003", ack, dat_sm);
        end
        total++;
        #1;
        rst_n = 1'b0;
        #1;
        if (ack !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL rstb_async_drop: got ack=%b err=%b want ack=0 err=0", ack, err);
        end
        total++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        if (ack !== 1'b0) begin bad++; $display("FAIL rstb_released: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b0) begin bad++; $display("FAIL rstb_restart_wait: got %b want 0", ack); end
        total++;
        cycle(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'hF, 3'b000, 2'b00);
        if (ack !== 1'b1 || dat_sm !== 32'hA000_0003) begin
            bad++; $display("FAIL rstb_restart: got ack=%b data=%h want ack=1 data=a0000003", ack, dat_sm);
        end
        total++;
        go_idle();
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_byte_write();
        test_fill();
        test_linear_burst();
        test_wrap4();
        test_out_of_range();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_bram_burst.md
WB_BRAM_BURST -- requirements
Module: wb_bram_burst

Interface
REQ-001 Parameter DATA_W, default 32: data bus width in bits; legal values are 32 and 64.
REQ-002 Parameter MEM_ADR_W, default 11: log2 of memory depth in words (11 gives 2048 words).
REQ-003 Parameter ADR_W, default 32: byte-address bus width.
REQ-004 clk  in  1: single clock; all logic on rising edge.
REQ-005 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 adr  in  ADR_W: byte address; word index = adr[MEM_ADR_W+OFS-1:OFS], where OFS = log2(DATA_W/8).
REQ-007 dat_ms  in  DATA_W: write data, master to slave.
REQ-008 dat_sm  out  DATA_W: read data, slave to master.
REQ-009 sel  in  DATA_W/8: byte lane enables.
REQ-010 we  in  1: write when 1, read when 0.
REQ-011 stb  in  1: strobe.
REQ-012 cyc  in  1: bus cycle.
REQ-013 cti  in  3: cycle type; 000 classic, 010 incrementing burst, 111 end of burst.
REQ-014 bte  in  2: burst type; 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-015 ack  out  1: normal termination.
REQ-016 err  out  1: error termination.
REQ-017 rty  out  1: retry; tied to 0.

Function
REQ-018 Memory depth SHALL be exactly 2**MEM_ADR_W words of DATA_W bits.
REQ-019 A beat SHALL be in range when adr[ADR_W-1:MEM_ADR_W+OFS] is all zero.
REQ-020 For an in-range beat, err SHALL be 0.
REQ-021 For an out-of-range beat, err SHALL be asserted combinationally in the same cycle as cyc&stb, with ack = 0 and no memory write.
REQ-022 Writes: ack SHALL be combinational cyc&stb&we&in-range, with zero wait states in any state, and only lanes with sel[i]=1 written at the clock edge.
REQ-023 Reads SHALL be driven by an FSM with states IDLE, RD and BURST.
REQ-024 IDLE: on cyc&stb&~we&in-range, read at adr and go to RD; no ack is given in this cycle (one wait state).
REQ-025 RD: ack is registered and asserted with dat_sm = mem[adr] from the previous cycle.
REQ-026 RD, on the acked beat: if cti = 010, prefetch the next address and go to BURST; otherwise go to IDLE.
REQ-027 BURST: ack SHALL be asserted each cycle in which cyc&stb&~we holds, adr equals the predicted address and the beat is in range, giving one beat per cycle.
REQ-028 BURST SHALL keep prefetching while cti = 010 and return to IDLE on an acked beat with cti = 111 or 000.
REQ-029 Next word address: bte 00 increments the full word index and wraps mod depth; bte 01/10/11 increments only the low 2/3/4 index bits, with upper bits held.
REQ-030 Any of the following SHALL de-assert ack that cycle and force IDLE: stb or cyc dropping in RD/BURST, adr mismatching the predicted address, we rising, or out-of-range.
REQ-031 A beat still requesting after the forced IDLE of REQ-030 SHALL restart with one wait state.
REQ-032 dat_sm SHALL change only on a memory read edge, and is valid only while ack = 1 on a read.
REQ-033 Write and read to the same word in consecutive cycles: the read SHALL return the newly written data.
REQ-034 ack and err SHALL never be asserted together, and never without cyc&stb.

Reset
REQ-035 rst_n = 0 SHALL immediately force state IDLE, the registered read ack to 0 and the predicted address to 0.
REQ-036 Under reset, ack = 0, err = 0 and rty = 0; dat_sm and memory contents are not reset.
REQ-037 Reset asserted mid-burst SHALL abort the burst; after release, the first read costs one wait state.

Structure
REQ-038 Package wb_pkg SHALL hold the cti_t and bte_t enums and the OFS computation function.
REQ-039 Sub-module bram_sp_be SHALL be the single-port, byte-enable, registered-output RAM, with no reset on the array.
REQ-040 The wrap/increment logic SHALL be a function in wb_pkg.

Verification
REQ-041 Single write to adr 0x10, sel 1111, data 0xDEADBEEF, then classic read of 0x10 -> write ack in the same cycle; read ack one cycle after stb with data 0xDEADBEEF.
REQ-042 Byte write to 0x20, sel 0010, data 0x0000AB00, over existing 0x11223344 -> a read returns 0x1122AB44.
REQ-043 Linear burst read from 0x0, 8 beats, cti 010 then 111 on the last beat -> acks on 8 consecutive cycles after one wait state; data matches words 0..7.
REQ-044 Wrap4 burst starting at word 6 -> adr order 6,7,4,5 is acked back-to-back; a master jumping to word 8 instead of 4 gets no ack that cycle, then a restart with a wait state.
REQ-045 Access to byte address 2**(MEM_ADR_W+OFS) -> err in the same cycle, no ack, and memory unchanged.
REQ-046 rst_n pulsed low for 1 cycle mid-burst at beat 3 -> ack drops asynchronously; after release, a new read costs one wait state.
